// File: rtl/cosim_pkg.sv
// Shared constants and record-kind encoding for the co-simulation commit queue.
package cosim_pkg;

  localparam int INST_LEN   = 32;
  localparam int HARTID_LEN = 32;

  typedef enum logic {
    KIND_COMMIT = 1'b0,
    KIND_TRAP   = 1'b1
  } kind_e;

  // Offset/total width must hold 0..COMMIT_WIDTH+1 (all lanes plus the trap).
  function automatic int off_width(input int commit_width);
    return $clog2(commit_width + 2);
  endfunction

endpackage

// File: rtl/cosim_lane_compact.sv
// Combinational prefix sum: slot offset of each valid lane, of the trap record,
// and the total number of records formed this cycle.
module cosim_lane_compact
  import cosim_pkg::*;
#(
  parameter int COMMIT_WIDTH = 3,
  parameter int OFF_W        = off_width(COMMIT_WIDTH)
) (
  input  logic [COMMIT_WIDTH-1:0]            in_valid,
  input  logic                               in_int_xcpt,
  output logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off,
  output logic [OFF_W-1:0]                   trap_off,
  output logic [OFF_W-1:0]                   total
);

  logic [COMMIT_WIDTH:0][OFF_W-1:0] run;

  assign run[0] = '0;

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_prefix
    assign lane_off[gi] = run[gi];
    assign run[gi+1]    = run[gi] + OFF_W'(in_valid[gi]);
  end

  // The trap record always follows the cycle's commits.
  assign trap_off = run[COMMIT_WIDTH];
  assign total    = run[COMMIT_WIDTH] + OFF_W'(in_int_xcpt);

endmodule

// File: rtl/cosim_commit_queue.sv
// Circular record queue between a multi-lane commit port and a co-simulation
// checker; a cycle's records are admitted all-or-nothing.
module cosim_commit_queue
  import cosim_pkg::*;
#(
  parameter int COMMIT_WIDTH = 3,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [COMMIT_WIDTH-1:0]        in_valid,
  input  logic [HARTID_LEN-1:0]          in_hartid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_pc,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]   in_mstatus,
  input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
  input  logic [COMMIT_WIDTH-1:0]        in_check,
  input  logic                           in_int_xcpt,
  input  logic [XLEN-1:0]                in_cause,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_kind,
  output logic [HARTID_LEN-1:0]          out_hartid,
  output logic [XLEN-1:0]                out_pc,
  output logic [INST_LEN-1:0]            out_inst,
  output logic [XLEN-1:0]                out_wdata,
  output logic [XLEN-1:0]                out_mstatus,
  output logic                           out_check,
  output logic                           overflow,
  output logic [63:0]                    commit_count,
  output logic [31:0]                    trap_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = off_width(COMMIT_WIDTH);

  logic [XLEN-1:0]       pc_mem      [DEPTH];
  logic [XLEN-1:0]       wdata_mem   [DEPTH];
  logic [XLEN-1:0]       mstatus_mem [DEPTH];
  logic [INST_LEN-1:0]   inst_mem    [DEPTH];
  logic [HARTID_LEN-1:0] hartid_mem  [DEPTH];
  logic                  check_mem   [DEPTH];
  kind_e                 kind_mem    [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic [63:0]      commit_count_reg;
  logic [31:0]      trap_count_reg;

  logic [COMMIT_WIDTH-1:0][OFF_W-1:0] lane_off;
  logic [OFF_W-1:0]                   trap_off;
  logic [OFF_W-1:0]                   total;
  logic                               admit;
  logic                               deq;
  logic [CNT_W-1:0]                   written;

  cosim_lane_compact #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .OFF_W        (OFF_W)
  ) u_compact (
    .in_valid    (in_valid),
    .in_int_xcpt (in_int_xcpt),
    .lane_off    (lane_off),
    .trap_off    (trap_off),
    .total       (total)
  );

  // Admission looks at the occupancy before this cycle's dequeue.
  assign admit   = CNT_W'(total) <= (CNT_W'(DEPTH) - count_reg);
  assign written = admit ? CNT_W'(total) : '0;
  assign deq     = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (admit) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) begin
          pc_mem     [tail_reg + PTR_W'(lane_off[i])] <= in_pc[i*XLEN +: XLEN];
          wdata_mem  [tail_reg + PTR_W'(lane_off[i])] <= in_wdata[i*XLEN +: XLEN];
          mstatus_mem[tail_reg + PTR_W'(lane_off[i])] <= in_mstatus[i*XLEN +: XLEN];
          inst_mem   [tail_reg + PTR_W'(lane_off[i])] <= in_inst[i*INST_LEN +: INST_LEN];
          hartid_mem [tail_reg + PTR_W'(lane_off[i])] <= in_hartid;
          check_mem  [tail_reg + PTR_W'(lane_off[i])] <= in_check[i];
          kind_mem   [tail_reg + PTR_W'(lane_off[i])] <= KIND_COMMIT;
        end
      end
      if (in_int_xcpt) begin
        pc_mem     [tail_reg + PTR_W'(trap_off)] <= '0;
        wdata_mem  [tail_reg + PTR_W'(trap_off)] <= in_cause;
        mstatus_mem[tail_reg + PTR_W'(trap_off)] <= '0;
        inst_mem   [tail_reg + PTR_W'(trap_off)] <= '0;
        hartid_mem [tail_reg + PTR_W'(trap_off)] <= in_hartid;
        check_mem  [tail_reg + PTR_W'(trap_off)] <= 1'b0;
        kind_mem   [tail_reg + PTR_W'(trap_off)] <= KIND_TRAP;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      overflow_reg     <= 1'b0;
      commit_count_reg <= '0;
      trap_count_reg   <= '0;
    end else begin
      head_reg  <= head_reg + PTR_W'(deq);
      tail_reg  <= tail_reg + PTR_W'(written);
      count_reg <= count_reg + written - CNT_W'(deq);
      if (!admit) overflow_reg <= 1'b1;
      if (deq && kind_mem[head_reg] == KIND_COMMIT) commit_count_reg <= commit_count_reg + 64'd1;
      if (deq && kind_mem[head_reg] == KIND_TRAP)   trap_count_reg   <= trap_count_reg + 32'd1;
    end
  end

  assign in_ready     = count_reg <= CNT_W'(DEPTH - (COMMIT_WIDTH + 1));
  assign out_valid    = count_reg != '0;
  assign out_kind     = kind_mem[head_reg];
  assign out_hartid   = hartid_mem[head_reg];
  assign out_pc       = pc_mem[head_reg];
  assign out_inst     = inst_mem[head_reg];
  assign out_wdata    = wdata_mem[head_reg];
  assign out_mstatus  = mstatus_mem[head_reg];
  assign out_check    = check_mem[head_reg];
  assign overflow     = overflow_reg;
  assign commit_count = commit_count_reg;
  assign trap_count   = trap_count_reg;

endmodule
